// File: rtl/aes_const_pack.sv
// AES constant tables shared by the round datapath and its reference models.
package aes_const_pack;

  localparam int unsigned AES_BLOCK_BYTES = 16;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_model_pack.sv
// Shared AES state layout and control encodings.
package aes_model_pack;

  // Row-major state: [0][0] occupies bits 127:120.
  typedef logic [0:3][0:3][7:0] byte_table;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage

// File: rtl/sbox_lane.sv
// One substitution lane: forward or inverse S-box lookup of a single byte.
module sbox_lane
  import aes_const_pack::*;
(
  input  logic [7:0] din,
  input  logic       inv,
  output logic [7:0] dout
);

  assign dout = inv ? INV_SBOX[din] : SBOX[din];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES S-box lanes walk the 16-byte block, one slot per cycle,
// with valid/ready handshakes on both sides.
module sub_bytes_iter
  import aes_const_pack::*, aes_model_pack::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  localparam int unsigned SLOTS = AES_BLOCK_BYTES / LANES;
  localparam int unsigned CNT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(SLOTS - 1);

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_lanes_check
    $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  sub_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             inv_q;
  byte_table        work;
  logic [3:0]       lane_idx [LANES];
  logic [7:0]       lane_out [LANES];

  // Lane l handles byte cnt*LANES+l; the 4-bit truncation folds the single-slot case to 0.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign lane_idx[l] = 4'(32'(cnt) * LANES + 32'(l));

    sbox_lane u_sbox (
      .din  (work[lane_idx[l][3:2]][lane_idx[l][1:0]]),
      .inv  (inv_q),
      .dout (lane_out[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      inv_q     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            work     <= byte_table'(in_block);
            inv_q    <= in_inv;
            cnt      <= '0;
            state    <= BUSY;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        BUSY: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            work[lane_idx[l][3:2]][lane_idx[l][1:0]] <= lane_out[l];
          end
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_SLOT) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign out_block = work;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: one instance per legal LANES value, a per-cycle behavioural
// model per instance, plus directed literal vectors, backpressure, reset and round-trip runs.
module tb_sub_bytes_iter;
  import aes_const_pack::*;

  logic         clk = 1'b0;
  logic [4:0]   rst, in_valid, in_inv, out_ready;
  logic [4:0]   in_ready, out_valid, busy;
  logic [127:0] in_block  [5];
  logic [127:0] out_block [5];

  int vec  = 0;
  int fail = 0;
  int lat_tab [5] = '{17, 9, 5, 3, 2};

  localparam logic [127:0] FIPS_IN  = 128'h19a09ae93df4c6f8e3e28d48be2b2a08;
  localparam logic [127:0] FIPS_OUT = 128'hd4e0b81e27bfb44111985d52aef1e530;

  always #5 clk = ~clk;

  function automatic void chk(string nm, int g, logic [127:0] act, logic [127:0] exp);
    vec++;
    if (act !== exp) begin
      fail++;
      $display("FAIL %s lanes=%0d t=%0t got=%h expected=%h", nm, 1 << g, $time, act, exp);
    end
  endfunction

  function automatic logic [127:0] sub_model(logic [127:0] b, logic inv);
    logic [127:0] r;
    logic [7:0]   t;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      t = b[127 - 8*i -: 8];
      r[127 - 8*i -: 8] = inv ? INV_SBOX[t] : SBOX[t];
    end
    return r;
  endfunction

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_iter #(.LANES(1 << g)) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_block  (in_block[g]),
      .in_inv    (in_inv[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_block (out_block[g]),
      .busy      (busy[g])
    );

    // Model: idle -> (16/LANES working cycles) -> holding result until taken.
    int           phase = 0;
    int           rem   = 0;
    bit           known = 1'b0;
    bit           fresh = 1'b0;
    logic [127:0] exp_blk = '0;

    initial forever begin
      @(negedge clk);
      if (known) begin
        chk("m_in_ready",  g, 128'(in_ready[g]),  128'(phase == 0));
        chk("m_out_valid", g, 128'(out_valid[g]), 128'(phase == 2));
        chk("m_busy",      g, 128'(busy[g]),      128'(phase != 0));
        if (phase == 2) chk("m_out_block", g, out_block[g], exp_blk);
        else if (phase == 0 && fresh) chk("m_reset_block", g, out_block[g], '0);
      end
      if (rst[g]) begin
        known = 1'b1;
        phase = 0;
        fresh = 1'b1;
      end else if (known) begin
        case (phase)
          0: if (in_valid[g]) begin
               exp_blk = sub_model(in_block[g], in_inv[g]);
               rem     = 16 >> g;
               phase   = 1;
               fresh   = 1'b0;
             end
          1: begin
               rem--;
               if (rem == 0) phase = 2;
             end
          default: if (out_ready[g]) phase = 0;
        endcase
      end
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic offer(input int g, input logic [127:0] blk, input logic inv, output bit ok);
    int guard = 0;
    ok = 1'b0;
    in_block[g] = blk;
    in_inv[g]   = inv;
    in_valid[g] = 1'b1;
    while (!ok && guard < 60) begin
      @(negedge clk);
      ok = in_ready[g];
      @(posedge clk); #1;
      guard++;
    end
    if (!ok) begin
      fail++;
      $display("FAIL accept_timeout lanes=%0d got=no_accept expected=accept", 1 << g);
    end
  endtask

  task automatic collect(input int g, input bit rnd, output logic [127:0] res, output int lat);
    int k   = 0;
    bit got = 1'b0;
    res = '0;
    lat = 0;
    while (!got && k < 100) begin
      @(negedge clk);
      k++;
      if (out_valid[g] && lat == 0) lat = k;
      if (out_valid[g] && out_ready[g]) begin
        res = out_block[g];
        got = 1'b1;
      end
      @(posedge clk); #1;
      if (rnd) out_ready[g] = 1'($urandom_range(0, 1));
    end
    if (!got) begin
      fail++;
      $display("FAIL output_timeout lanes=%0d got=no_output expected=output", 1 << g);
    end
  endtask

  task automatic xfer(input int g, input logic [127:0] blk, input logic inv, input bit rnd,
                      output logic [127:0] res, output int lat);
    bit ok;
    if (rnd) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      out_ready[g] = 1'($urandom_range(0, 1));
    end else begin
      out_ready[g] = 1'b1;
    end
    offer(g, blk, inv, ok);
    in_valid[g] = 1'b0;
    in_block[g] = {$urandom(), $urandom(), $urandom(), $urandom()};
    in_inv[g]   = 1'($urandom_range(0, 1));
    collect(g, rnd, res, lat);
  endtask

  task automatic rnd_run(input int g);
    logic [127:0] x, y, z;
    int lat;
    for (int n = 0; n < 100; n++) begin
      x = {$urandom(), $urandom(), $urandom(), $urandom()};
      xfer(g, x, 1'b0, 1'b1, y, lat);
      xfer(g, y, 1'b1, 1'b1, z, lat);
      chk("roundtrip", g, z, x);
    end
  endtask

  initial begin
    logic [127:0] res;
    int lat;
    bit ok;
    int k;

    rst = '1; in_valid = '0; in_inv = '0; out_ready = '0;
    for (int g = 0; g < 5; g++) in_block[g] = '0;
    repeat (2) @(posedge clk);
    #1 rst = '0;
    @(negedge clk);
    for (int g = 0; g < 5; g++) begin
      chk("rst_in_ready",  g, 128'(in_ready[g]),  128'(1));
      chk("rst_out_valid", g, 128'(out_valid[g]), 128'(0));
      chk("rst_busy",      g, 128'(busy[g]),      128'(0));
      chk("rst_out_block", g, out_block[g], '0);
    end
    @(posedge clk); #1;

    // FIPS-197 round-1 state through the 4-lane engine, both directions.
    xfer(2, FIPS_IN, 1'b0, 1'b0, res, lat);
    chk("fips_fwd", 2, res, FIPS_OUT);
    chk("fips_fwd_latency", 2, 128'(lat), 128'(5));
    xfer(2, FIPS_OUT, 1'b1, 1'b0, res, lat);
    chk("fips_inv", 2, res, FIPS_IN);

    // All-zero block on every lane count.
    for (int g = 0; g < 5; g++) begin
      xfer(g, '0, 1'b0, 1'b0, res, lat);
      chk("zero_fwd", g, res, {16{8'h63}});
      chk("zero_fwd_latency", g, 128'(lat), 128'(lat_tab[g]));
      xfer(g, '0, 1'b1, 1'b0, res, lat);
      chk("zero_inv", g, res, {16{8'h52}});
      chk("zero_inv_latency", g, 128'(lat), 128'(lat_tab[g]));
    end

    // Backpressure with a second block waiting on in_valid.
    out_ready[2] = 1'b0;
    offer(2, FIPS_IN, 1'b0, ok);
    in_block[2] = FIPS_OUT;
    in_inv[2]   = 1'b1;
    k = 0;
    while (k < 20) begin
      @(negedge clk);
      if (out_valid[2]) break;
      @(posedge clk); #1;
      k++;
    end
    chk("bp_reached_done", 2, 128'(out_valid[2]), 128'(1));
    @(posedge clk); #1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("bp_out_valid", 2, 128'(out_valid[2]), 128'(1));
      chk("bp_out_block", 2, out_block[2], FIPS_OUT);
      chk("bp_in_ready",  2, 128'(in_ready[2]),  128'(0));
      @(posedge clk); #1;
    end
    out_ready[2] = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_in_ready",  2, 128'(in_ready[2]),  128'(1));
    chk("bp_idle_out_valid", 2, 128'(out_valid[2]), 128'(0));
    @(posedge clk); #1;
    in_valid[2] = 1'b0;
    collect(2, 1'b0, res, lat);
    chk("bp_second_block", 2, res, FIPS_IN);
    chk("bp_second_latency", 2, 128'(lat), 128'(5));

    // Reset two cycles into BUSY discards the block.
    out_ready[2] = 1'b1;
    offer(2, FIPS_IN, 1'b0, ok);
    in_valid[2] = 1'b0;
    @(posedge clk); #1;
    rst[2] = 1'b1;
    @(posedge clk); #1;
    rst[2] = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 2, 128'(out_valid[2]), 128'(0));
    chk("midrst_out_block", 2, out_block[2], '0);
    chk("midrst_in_ready",  2, 128'(in_ready[2]),  128'(1));
    chk("midrst_busy",      2, 128'(busy[2]),      128'(0));
    @(posedge clk); #1;
    xfer(2, FIPS_IN, 1'b0, 1'b0, res, lat);
    chk("midrst_fresh_block", 2, res, FIPS_OUT);

    // Throttled round-trip regression on all engines at once.
    fork
      rnd_run(0);
      rnd_run(1);
      rnd_run(2);
      rnd_run(3);
      rnd_run(4);
    join

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, fail);
    $finish;
  end

endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Sequential, parametrised SubBytes engine for the AES-128 datapath. Accepts one 128-bit state block (the `aes_model_pack::byte_table` layout) over a valid/ready handshake. Substitutes its 16 bytes through `LANES` parallel S-box lanes per cycle, using either the forward or the inverse S-box. Returns the block over a second valid/ready handshake. It is the successor of the purely combinational substitution stage, trading area for latency in the round pipeline and adding decryption support.

## Interface

Parameters:
- `LANES`, default 4. Bytes substituted per cycle. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.

Ports:
- `clk` input, 1 bit. Single clock.
- `rst` input, 1 bit. Synchronous, active-high reset.
- `in_valid` input, 1 bit. Input block offered.
- `in_ready` output, 1 bit. Engine can accept a block.
- `in_block` input, 128 bits. State block, row-major, byte [0][0] at bits 127:120.
- `in_inv` input, 1 bit. 0 = forward S-box, 1 = inverse S-box. Sampled with the block.
- `out_valid` output, 1 bit. Result block available.
- `out_ready` input, 1 bit. Downstream accepts the result.
- `out_block` output, 128 bits. Substituted block, same byte layout as `in_block`.
- `busy` output, 1 bit. High in BUSY and DONE.

## Operation

- FSM with three states: IDLE, BUSY, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: latch `in_block` into the work register, latch `in_inv`, clear the byte counter, go to BUSY.
- BUSY:
  - Each cycle, the `LANES` bytes at counter slot `k` (bytes k·LANES … k·LANES+LANES−1, byte 0 = bits 127:120) are replaced in place by sbox(byte) or inv_sbox(byte).
  - The counter has width max(1, $clog2(16/LANES)) and increments by 1.
  - On the last slot (k = 16/LANES−1), go to DONE.
  - The counter wraps to 0; it is never compared past the last slot.
- DONE:
  - `out_valid`=1 and `out_block` = work register.
  - Both are held stable until `out_ready`.
  - On `out_valid && out_ready`, go to IDLE.
- `in_ready` is 0 in BUSY and DONE. `in_valid` is ignored there, including a simultaneous `in_valid` in the cycle DONE is left; that block is accepted in the following IDLE cycle.
- `in_block` and `in_inv` are don't-care except in the accept cycle. Changes during BUSY have no effect.
- `out_ready` is ignored outside DONE.

Reset (`rst`=1 at a clock edge, any state, including mid-BUSY):
- state → IDLE, counter → 0, work register → 0, mode → 0.
- Outputs after that edge: `out_valid`=0, `out_block`=0, `in_ready`=1, `busy`=0.
- A partially substituted block is discarded, with no output.

## Timing

- Accept edge = cycle 0.
- BUSY occupies cycles 1 … 16/LANES.
- `out_valid` rises 16/LANES+1 edges after accept. Examples: `LANES`=16 → 2 edges; `LANES`=4 → 5; `LANES`=1 → 17.
- With `out_ready` held high, a block occupies 16/LANES+2 cycles. The next accept is possible on the cycle after the output handshake.
- All outputs are registered or decoded from the state register. There is no combinational path from `in_valid` or `out_ready` to any output.

## Structure

In `aes_const_pack`:
- `SBOX` and `INV_SBOX`: 256×8 constant arrays.
- `AES_BLOCK_BYTES = 16`.

In `aes_model_pack`:
- Reuse `byte_table` for the block type.
- Add a `sub_state_e` enum (IDLE, BUSY, DONE).

Sub-module `sbox_lane`:
- Combinational, one byte in and one byte out, with an `inv` select, indexing the two package tables.
- `sub_bytes_iter` instantiates `LANES` copies in a generate loop.
- A multiplexer selects the current slot from the work register.

## Test plan

1. `LANES`=4, forward. `in_block`=19a09ae93df4c6f8e3e28d48be2b2a08 → `out_valid` 5 edges after accept, `out_block`=d4e0b81e27bfb44111985d52aef1e530.
2. `LANES`=4, inverse. `in_block`=d4e0b81e27bfb44111985d52aef1e530 → `out_block`=19a09ae93df4c6f8e3e28d48be2b2a08.
3. Each of `LANES` ∈ {1, 2, 8, 16}, block of all 00.
   - Forward → all 63.
   - Inverse → all 52.
   - Latency is 17/9/3/2 edges respectively.
4. Backpressure:
   - Hold `out_ready`=0 for 10 cycles in DONE → `out_valid` and `out_block` stable, and `in_ready`=0 despite `in_valid`=1.
   - Release → one handshake, then IDLE.
   - A second block is accepted the next cycle with its own `in_inv`.
5. Reset mid-operation: assert `rst` 2 cycles into BUSY → the next cycle shows `out_valid`=0, `out_block`=0, `in_ready`=1. A fresh block then completes correctly.
6. Random regression, 1000 blocks with random mode, random `in_valid`/`out_ready` throttling, all legal `LANES` → every output matches a model built on the package tables. Inverse(forward(x)) = x.
